// File: rtl/dca_matrix_row_assembler_pkg.sv
// Shared DCA tensor sizing: row width, words per row and counter widths.
// Latency: n/a (compile-time constants and pure functions only).
// Backpressure: n/a.
//
// Contents:
//   BW_WORD_DEFAULT - default LSU word width
//   bw_tensor_row   - scalars per row times scalar width
//   words_per_row   - number of input words that make up one row
//   cnt_width       - width of a counter over 0..n-1 (never below 1 bit)
package dca_matrix_row_assembler_pkg;

  localparam int BW_WORD_DEFAULT = 32;

  function automatic int bw_tensor_row(input int matrix_size, input int bw_scalar);
    return matrix_size * bw_scalar;
  endfunction

  function automatic int words_per_row(input int bw_row, input int bw_word);
    return bw_row / bw_word;
  endfunction

  // $clog2(1) is 0, and $clog2(2) is 1; a counter must keep at least one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dca_matrix_row_assembler_if.sv
// Valid/ready stream bundle with an end-of-group marker, used for word and row ports.
// Latency: n/a (wiring only).
// Backpressure: master holds wvalid/wdata/wlast until the slave raises wready.
//
// Signals:
//   wvalid - master has a beat
//   wready - slave accepts the beat this cycle
//   wdata  - payload, BW bits
//   wlast  - marks the final beat of a group (matrix)
interface dca_matrix_row_assembler_if
  import dca_matrix_row_assembler_pkg::*;
#(
  parameter int BW = BW_WORD_DEFAULT
);

  logic          wvalid;
  logic          wready;
  logic [BW-1:0] wdata;
  logic          wlast;

  modport master (
    output wvalid,
    output wdata,
    output wlast,
    input  wready
  );

  modport slave (
    input  wvalid,
    input  wdata,
    input  wlast,
    output wready
  );

endinterface

// File: rtl/dca_matrix_row_assembler_word_packer.sv
// Packs narrow words into one tensor row and tracks word/row position within a matrix.
// Latency: the row is offered (full) the cycle after its last word is accepted.
// Backpressure: word_rdy stays low while a finished row waits for take.
//
// Ports:
//   clk, rstnn        - clock, async active-low reset
//   clear, enable     - synchronous flush, advance enable
//   word_vld/rdy/dat  - word intake handshake
//   word_final        - the next accepted word is the final word of the final row
//   full, take        - finished row offered / taken by the output stage
//   row_dat, row_last - finished row and its end-of-matrix flag
//   partial           - some words of a row are already held
module dca_row_word_packer
  import dca_matrix_row_assembler_pkg::*;
#(
  parameter  int MATRIX_SIZE      = 8,
  parameter  int BW_TENSOR_SCALAR = 32,
  parameter  int BW_WORD          = BW_WORD_DEFAULT,
  localparam int BW_TENSOR_ROW    = bw_tensor_row(MATRIX_SIZE, BW_TENSOR_SCALAR),
  localparam int WORDS_PER_ROW    = words_per_row(BW_TENSOR_ROW, BW_WORD)
) (
  input  logic                     clk,
  input  logic                     rstnn,
  input  logic                     clear,
  input  logic                     enable,
  input  logic                     word_vld,
  output logic                     word_rdy,
  input  logic [BW_WORD-1:0]       word_dat,
  output logic                     word_final,
  output logic                     full,
  input  logic                     take,
  output logic [BW_TENSOR_ROW-1:0] row_dat,
  output logic                     row_last,
  output logic                     partial
);

  localparam int CW = cnt_width(WORDS_PER_ROW);
  localparam int RW = cnt_width(MATRIX_SIZE);
  localparam logic [CW-1:0] LAST_WORD = CW'(WORDS_PER_ROW - 1);
  localparam logic [RW-1:0] LAST_ROW  = RW'(MATRIX_SIZE - 1);

  logic [BW_TENSOR_ROW-1:0] asm_row;
  logic [CW-1:0]            word_cnt;
  logic [RW-1:0]            row_cnt;
  logic                     asm_full;
  logic                     asm_last;
  logic                     word_acc;

  // Reset is folded in so intake is visibly closed while rstnn is low.
  assign word_rdy   = rstnn & enable & ~asm_full & ~clear;
  assign word_acc   = word_vld & word_rdy;
  assign word_final = (word_cnt == LAST_WORD) & (row_cnt == LAST_ROW);
  assign full       = asm_full;
  assign row_dat    = asm_row;
  assign row_last   = asm_last;
  assign partial    = (word_cnt != '0);

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      asm_row  <= '0;
      word_cnt <= '0;
      row_cnt  <= '0;
      asm_full <= 1'b0;
      asm_last <= 1'b0;
    end else if (clear) begin
      // Row contents and asm_last are left as-is; they are rewritten before reuse.
      word_cnt <= '0;
      row_cnt  <= '0;
      asm_full <= 1'b0;
    end else begin
      // take needs asm_full and intake needs ~asm_full, so they never coincide.
      if (take) begin
        asm_full <= 1'b0;
      end
      if (word_acc) begin
        // Word k lands in slice k, so word 0 sits in the LSBs.
        for (int k = 0; k < WORDS_PER_ROW; k++) begin
          if (word_cnt == CW'(k)) begin
            asm_row[k*BW_WORD +: BW_WORD] <= word_dat;
          end
        end
        if (word_cnt == LAST_WORD) begin
          word_cnt <= '0;
          asm_full <= 1'b1;
          asm_last <= (row_cnt == LAST_ROW);
          row_cnt  <= (row_cnt == LAST_ROW) ? '0 : row_cnt + RW'(1);
        end else begin
          word_cnt <= word_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/dca_matrix_row_assembler.sv
// Assembles LSU words into tensor rows for the DCA matrix load stage, flagging each matrix's last row.
// Latency: row valid two cycles after its last word is accepted when the output register is free.
// Backpressure: holds up to two rows (assembly + output); word intake stalls until the output drains.
//
// Ports:
//   clk, rstnn       - clock, async active-low reset
//   clear            - synchronous flush of counters, valid and error state
//   enable           - gates word intake and assembly-to-output transfer
//   busy             - any partial row, finished row or output row held
//   protocol_error   - sticky: producer wlast disagreed with the block's own count
//   word             - word stream in (slave side)
//   load_tensor_row  - row stream out (master side), wdata is the full row
//
// Optional build macro DCA_ROW_ASSEMBLER_LAST_CHECK_EN enables the wlast consistency check;
// without it word.wlast is ignored and protocol_error is constant 0.
module dca_matrix_row_assembler
  import dca_matrix_row_assembler_pkg::*;
#(
  parameter  int MATRIX_SIZE      = 8,
  parameter  int BW_TENSOR_SCALAR = 32,
  parameter  int BW_WORD          = BW_WORD_DEFAULT,
  localparam int BW_TENSOR_ROW    = bw_tensor_row(MATRIX_SIZE, BW_TENSOR_SCALAR)
) (
  input  logic                          clk,
  input  logic                          rstnn,
  input  logic                          clear,
  input  logic                          enable,
  output logic                          busy,
  output logic                          protocol_error,
  dca_matrix_row_assembler_if.slave     word,
  dca_matrix_row_assembler_if.master    load_tensor_row
);

  typedef struct packed {
    logic                     last;
    logic [BW_TENSOR_ROW-1:0] data;
  } row_t;

  logic                     word_rdy;
  logic                     word_final;
  logic                     asm_full;
  logic                     asm_last;
  logic [BW_TENSOR_ROW-1:0] asm_row;
  logic                     partial;
  logic                     take;
  logic                     out_valid;
  row_t                     out_q;

  dca_row_word_packer #(
    .MATRIX_SIZE      (MATRIX_SIZE),
    .BW_TENSOR_SCALAR (BW_TENSOR_SCALAR),
    .BW_WORD          (BW_WORD)
  ) u_packer (
    .clk        (clk),
    .rstnn      (rstnn),
    .clear      (clear),
    .enable     (enable),
    .word_vld   (word.wvalid),
    .word_rdy   (word_rdy),
    .word_dat   (word.wdata),
    .word_final (word_final),
    .full       (asm_full),
    .take       (take),
    .row_dat    (asm_row),
    .row_last   (asm_last),
    .partial    (partial)
  );

  assign word.wready = word_rdy;

  // Refill is allowed in the same cycle the consumer drains the output register.
  assign take = enable & asm_full & (~out_valid | load_tensor_row.wready);

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      out_valid <= 1'b0;
      out_q     <= '0;
    end else if (clear) begin
      out_valid <= 1'b0;
    end else if (take) begin
      out_valid <= 1'b1;
      out_q     <= '{last: asm_last, data: asm_row};
    end else if (out_valid && load_tensor_row.wready) begin
      // Completes independently of enable so a pending handshake never hangs.
      out_valid <= 1'b0;
    end
  end

  assign load_tensor_row.wvalid = out_valid;
  assign load_tensor_row.wlast  = out_q.last;
  assign load_tensor_row.wdata  = out_q.data;

  assign busy = partial | asm_full | out_valid;

`ifdef DCA_ROW_ASSEMBLER_LAST_CHECK_EN
  logic err_q;

  // The producer's marker must line up exactly with the final word of the final row.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      err_q <= 1'b0;
    end else if (clear) begin
      err_q <= 1'b0;
    end else if (word.wvalid && word_rdy && (word.wlast != word_final)) begin
      err_q <= 1'b1;
    end
  end

  assign protocol_error = err_q;
`else
  logic unused_last_check;
  assign unused_last_check = word.wlast ^ word_final;
  assign protocol_error    = 1'b0;
`endif

endmodule
